// File: rtl/lote_inspecao_ctrl.sv
// Batch-inspection sequencer: settles the sensor word, samples the classifier once,
// holds a one-hot verdict with buzzer, counts verdicts and releases the conveyor.
//
//  state     | meaning
//  S_IDLE    | waiting for a batch under the sensors
//  S_SETTLE  | sensor word must stay unchanged for SETTLE_CYCLES cycles
//  S_EVAL    | one cycle; verdict and counters captured at its closing edge
//  S_REPORT  | verdict shown for HOLD_CYCLES cycles, buzzer beeps on refusal
//  S_RELEASE | conveyor advances until the batch leaves the sensors
module lote_inspecao_ctrl #(
   parameter int SETTLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int BEEP_CYCLES   = 2,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lote_presente,
   input  logic [4:0]       sensores,
   input  logic             clr_cnt,
   output logic [4:0]       sensores_q,
   input  logic             ver_aceito,
   input  logic             ver_comprometido,
   output logic             lote_aceito,
   output logic             lote_comprometido,
   output logic             lote_recusado,
   output logic             verdict_valid,
   output logic             sound_buzzer,
   output logic             esteira_avanca,
   output logic [CNT_W-1:0] cnt_aceito,
   output logic [CNT_W-1:0] cnt_comprometido,
   output logic [CNT_W-1:0] cnt_recusado
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
   localparam int BW = (BEEP_CYCLES   > 1) ? $clog2(BEEP_CYCLES)   : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_EVAL,
      S_REPORT,
      S_RELEASE
   } state_t;

   state_t          state, state_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [HW-1:0]   hold_cnt;
   logic [BW-1:0]   beep_cnt;
   logic            v_acc, v_comp, v_rec;
   logic            sens_stable;

   // Neither or both classifier outputs is treated as a refusal (fail-safe).
   assign v_acc       = ver_aceito & ~ver_comprometido;
   assign v_comp      = ver_comprometido & ~ver_aceito;
   assign v_rec       = ~(ver_aceito ^ ver_comprometido);
   assign sens_stable = (sensores == sensores_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (lote_presente) state_nxt = S_SETTLE;
         S_SETTLE: begin
            if (!lote_presente)                       state_nxt = S_IDLE;
            else if (sens_stable && settle_cnt == '0) state_nxt = S_EVAL;
         end
         S_EVAL:    state_nxt = S_REPORT;
         S_REPORT:  if (hold_cnt == '0) state_nxt = S_RELEASE;
         S_RELEASE: if (!lote_presente) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sensores_q        <= '0;
         settle_cnt        <= '0;
         hold_cnt          <= '0;
         beep_cnt          <= '0;
         lote_aceito       <= 1'b0;
         lote_comprometido <= 1'b0;
         lote_recusado     <= 1'b0;
         verdict_valid     <= 1'b0;
         sound_buzzer      <= 1'b0;
         esteira_avanca    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (lote_presente) begin
                  sensores_q <= sensores;
                  settle_cnt <= SW'(SETTLE_CYCLES - 1);
               end
            end
            S_SETTLE: begin
               if (lote_presente) begin
                  if (!sens_stable) begin
                     sensores_q <= sensores;
                     settle_cnt <= SW'(SETTLE_CYCLES - 1);
                  end else if (settle_cnt != '0) begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
            end
            S_EVAL: begin
               lote_aceito       <= v_acc;
               lote_comprometido <= v_comp;
               lote_recusado     <= v_rec;
               verdict_valid     <= 1'b1;
               sound_buzzer      <= v_rec;
               hold_cnt          <= HW'(HOLD_CYCLES - 1);
               beep_cnt          <= BW'(BEEP_CYCLES - 1);
            end
            S_REPORT: begin
               if (hold_cnt == '0) begin
                  esteira_avanca <= 1'b1;
                  sound_buzzer   <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
                  if (beep_cnt == '0) begin
                     sound_buzzer <= lote_recusado & ~sound_buzzer;
                     beep_cnt     <= BW'(BEEP_CYCLES - 1);
                  end else begin
                     beep_cnt <= beep_cnt - 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (!lote_presente) begin
                  lote_aceito       <= 1'b0;
                  lote_comprometido <= 1'b0;
                  lote_recusado     <= 1'b0;
                  verdict_valid     <= 1'b0;
                  esteira_avanca    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Clear has priority over the increment captured at the end of EVAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_aceito       <= '0;
         cnt_comprometido <= '0;
         cnt_recusado     <= '0;
      end else if (clr_cnt) begin
         cnt_aceito       <= '0;
         cnt_comprometido <= '0;
         cnt_recusado     <= '0;
      end else if (state == S_EVAL) begin
         if (v_acc && cnt_aceito != {CNT_W{1'b1}})
            cnt_aceito <= cnt_aceito + 1'b1;
         if (v_comp && cnt_comprometido != {CNT_W{1'b1}})
            cnt_comprometido <= cnt_comprometido + 1'b1;
         if (v_rec && cnt_recusado != {CNT_W{1'b1}})
            cnt_recusado <= cnt_recusado + 1'b1;
      end
   end

endmodule
